// File: rtl/minmax_seq.sv
// minmax_seq: streaming signed min/max over one time-shared slt comparator.
// Define MINMAX_SEQ_ARGIDX_EN to add out_min_idx/out_max_idx position outputs.
module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);
  logic [N:0] d;
  // Sign-extending by one bit keeps the difference free of overflow.
  assign d = {a_i[N-1], a_i} - {b_i[N-1], b_i};
  assign lt_o = d[N];
endmodule

module minmax_seq #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_count
`ifdef MINMAX_SEQ_ARGIDX_EN
  ,
  output logic [CW-1:0] out_min_idx,
  output logic [CW-1:0] out_max_idx
`endif
);
  typedef enum logic [1:0] {ACCEPT, CMP_MIN, CMP_MAX, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] min_q, min_d, max_q, max_d, op_q, op_d, lt_a, lt_b;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic last_q, last_d, lt, xfer;
`ifdef MINMAX_SEQ_ARGIDX_EN
  logic [CW-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d, op_idx_q, op_idx_d;
`endif
  assign lt_a = state_q == CMP_MIN ? op_q : max_q;
  assign lt_b = state_q == CMP_MIN ? min_q : op_q;
  slt #(.N(N)) u_slt (.a_i(lt_a), .b_i(lt_b), .lt_o(lt));
  assign xfer = in_valid & (state_q == ACCEPT);
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
  always_comb begin
    state_d = state_q;
    min_d = min_q;
    max_d = max_q;
    op_d = op_q;
    last_d = last_q;
    cnt_d = cnt_q;
`ifdef MINMAX_SEQ_ARGIDX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    op_idx_d = op_idx_q;
`endif
    case (state_q)
      ACCEPT: if (xfer) begin
        if (cnt_q == '0) begin
          min_d = in_data;
          max_d = in_data;
          cnt_d = CW'(1);
`ifdef MINMAX_SEQ_ARGIDX_EN
          min_idx_d = '0;
          max_idx_d = '0;
`endif
          state_d = in_last ? DONE : ACCEPT;
        end else begin
          op_d = in_data;
          last_d = in_last;
          cnt_d = cnt_inc;
`ifdef MINMAX_SEQ_ARGIDX_EN
          op_idx_d = cnt_q;
`endif
          state_d = CMP_MIN;
        end
      end
      CMP_MIN: begin
        if (lt) begin
          min_d = op_q;
`ifdef MINMAX_SEQ_ARGIDX_EN
          min_idx_d = op_idx_q;
`endif
        end
        state_d = CMP_MAX;
      end
      CMP_MAX: begin
        if (lt) begin
          max_d = op_q;
`ifdef MINMAX_SEQ_ARGIDX_EN
          max_idx_d = op_idx_q;
`endif
        end
        state_d = last_q ? DONE : ACCEPT;
      end
      default: if (out_ready) begin
        min_d = '0;
        max_d = '0;
        cnt_d = '0;
`ifdef MINMAX_SEQ_ARGIDX_EN
        min_idx_d = '0;
        max_idx_d = '0;
`endif
        state_d = ACCEPT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCEPT;
      min_q <= '0;
      max_q <= '0;
      op_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
`ifdef MINMAX_SEQ_ARGIDX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
      op_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      max_q <= max_d;
      op_q <= op_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
`ifdef MINMAX_SEQ_ARGIDX_EN
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      op_idx_q <= op_idx_d;
`endif
    end
  end
  assign in_ready = ~rst & (state_q == ACCEPT);
  assign out_valid = ~rst & (state_q == DONE);
  assign out_min = rst ? '0 : min_q;
  assign out_max = rst ? '0 : max_q;
  assign out_count = rst ? '0 : cnt_q;
`ifdef MINMAX_SEQ_ARGIDX_EN
  assign out_min_idx = rst ? '0 : min_idx_q;
  assign out_max_idx = rst ? '0 : max_idx_q;
`endif
endmodule

// File: tb/tb_minmax_seq.sv
// tb_minmax_seq: table-driven streams with a result scoreboard plus timing and reset sequences.
module tb_minmax_seq;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready, in_ready, out_valid;
  logic [31:0] in_data, out_min, out_max;
  logic [15:0] out_count;
`ifdef MINMAX_SEQ_ARGIDX_EN
  logic [15:0] out_min_idx, out_max_idx;
`endif
  minmax_seq #(.N(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
    .out_count(out_count)
`ifdef MINMAX_SEQ_ARGIDX_EN
    , .out_min_idx(out_min_idx), .out_max_idx(out_max_idx)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int len;
    logic [4:0][31:0] w;
    logic [31:0] mn, mx;
    logic [15:0] cnt, mni, mxi;
  } vec_t;
  vec_t tbl[6];
  vec_t sbq[$];
  int checks = 0, errors = 0;
  function automatic vec_t mk(int len, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              logic [31:0] d, logic [31:0] e, logic [31:0] mn,
                              logic [31:0] mx, logic [15:0] cnt, logic [15:0] mni,
                              logic [15:0] mxi);
    mk.len = len;
    mk.w[0] = a;
    mk.w[1] = b;
    mk.w[2] = c;
    mk.w[3] = d;
    mk.w[4] = e;
    mk.mn = mn;
    mk.mx = mx;
    mk.cnt = cnt;
    mk.mni = mni;
    mk.mxi = mxi;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(vec_t v);
    for (int i = 0; i < v.len; i++) begin
      int t;
      in_valid = 1'b1;
      in_data = v.w[i];
      in_last = (i == v.len - 1);
      t = 0;
      while (!in_ready && t < 100) begin
        tick;
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 0, 1);
      tick;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic recv;
    vec_t v;
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      tick;
      t++;
    end
    if (t >= 100) chk("out_valid_timeout", 0, 1);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      v = sbq.pop_front();
      chk("min", out_min, v.mn);
      chk("max", out_max, v.mx);
      chk("count", 32'(out_count), 32'(v.cnt));
`ifdef MINMAX_SEQ_ARGIDX_EN
      chk("min_idx", 32'(out_min_idx), 32'(v.mni));
      chk("max_idx", 32'(out_max_idx), 32'(v.mxi));
`endif
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("valid_after_handshake", 32'(out_valid), 0);
    chk("count_after_handshake", 32'(out_count), 0);
    chk("ready_after_handshake", 32'(in_ready), 1);
  endtask
  task automatic run(vec_t v);
    int lat;
    sbq.push_back(v);
    send(v);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
    chk("latency", lat, v.len == 1 ? 0 : 2);
    recv;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int xe[3];
    int idx, first_valid;
    tbl[0] = mk(5, 5, -3, 7, 7, -3, -3, 7, 5, 1, 2);
    tbl[1] = mk(2, 32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 32'h80000000, 32'h7FFFFFFF, 2, 1, 0);
    tbl[2] = mk(1, -1, 0, 0, 0, 0, -1, -1, 1, 0, 0);
    tbl[3] = mk(3, 3, 3, 3, 0, 0, 3, 3, 3, 0, 0);
    tbl[4] = mk(4, 32'h80000000, 0, 32'h7FFFFFFF, -1, 0, 32'h80000000, 32'h7FFFFFFF, 4, 0, 2);
    tbl[5] = mk(4, 10, 9, 8, 11, 0, 8, 11, 4, 2, 3);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_min", out_min, 0);
    chk("post_rst_max", out_max, 0);
    chk("post_rst_count", 32'(out_count), 0);
    for (int k = 0; k < 6; k++) run(tbl[k]);
    sbq.push_back(mk(3, 1, 2, 3, 0, 0, 1, 3, 3, 0, 2));
    in_valid = 1'b1;
    in_data = 1;
    in_last = 1'b0;
    idx = 0;
    first_valid = -1;
    for (int e = 0; e < 12 && first_valid < 0; e++) begin
      logic xf;
      xf = in_valid & in_ready;
      tick;
      if (xf) begin
        xe[idx] = e;
        idx++;
        if (idx == 3) begin
          in_valid = 1'b0;
          in_last = 1'b0;
        end else begin
          in_data = 32'(idx + 1);
          in_last = (idx == 2);
        end
      end
      if (out_valid) first_valid = e;
    end
    chk("xfer_edge0", xe[0], 0);
    chk("xfer_edge1", xe[1], 1);
    chk("xfer_edge2", xe[2], 4);
    chk("valid_edge", first_valid, 6);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_min", out_min, 1);
      chk("hold_max", out_max, 3);
    end
    recv;
    in_valid = 1'b1;
    in_data = 4;
    tick;
    in_data = 9;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", 32'(in_ready), 1);
    chk("mid_post_out_valid", 32'(out_valid), 0);
    chk("mid_post_min", out_min, 0);
    chk("mid_post_max", out_max, 0);
    chk("mid_post_count", 32'(out_count), 0);
    run(mk(1, 2, 0, 0, 0, 0, 2, 2, 1, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
